// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant in IDLE, AMBA 3 SETUP/ACCESS
// sequencing, and a bounded PREADY wait that aborts the transfer with an error.
module apb_master_arbiter #(
    parameter int unsigned APB_ADDR_WIDTH = 4,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT        = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [1:0]                  req_valid,
    input  logic [1:0]                  req_write,
    input  logic [2*APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*APB_DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                  req_ready,
    output logic [1:0]                  resp_valid,
    output logic [APB_DATA_WIDTH-1:0]   resp_rdata,
    output logic                        resp_err,
    output logic                        PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [APB_ADDR_WIDTH-1:0]   PADDR,
    output logic [APB_DATA_WIDTH-1:0]   PWDATA,
    input  logic [APB_DATA_WIDTH-1:0]   PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state, state_nxt;
    logic            gnt, gnt_nxt, last_gnt;
    logic            take, done_ok, done_to;
    logic [CW-1:0]   wait_cnt;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        req_ready = '0;
        take      = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (state)
            IDLE: begin
                // req_ready is combinational, so it is held low while in reset
                if (PRESETn && (|req_valid)) begin
                    take      = 1'b1;
                    gnt_nxt   = (&req_valid) ? ~last_gnt : req_valid[1];
                    req_ready = gnt_nxt ? 2'b10 : 2'b01;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    done_to   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_gnt   <= 1'b1;
            wait_cnt   <= '0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= '0;
            if (take) begin
                gnt    <= gnt_nxt;
                PWRITE <= req_write[gnt_nxt];
                PADDR  <= req_addr[(gnt_nxt ? APB_ADDR_WIDTH : 0) +: APB_ADDR_WIDTH];
                PWDATA <= req_wdata[(gnt_nxt ? APB_DATA_WIDTH : 0) +: APB_DATA_WIDTH];
            end
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (done_ok || done_to) begin
                resp_valid <= gnt ? 2'b10 : 2'b01;
                resp_rdata <= (done_ok && !PWRITE) ? PRDATA : '0;
                resp_err   <= done_to | PSLVERR;
                last_gnt   <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomised bench for apb_master_arbiter: directed scenarios plus a random
// transfer stream checked against a transaction-level round-robin model.
module tb_apb_master_arbiter;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int AW2 = 2 * AW;
    localparam int TO  = 16;

    logic           PCLK, PRESETn;
    logic [1:0]     req_valid, req_write, req_ready, resp_valid;
    logic [AW2-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]  resp_rdata, PWDATA, PRDATA;
    logic           resp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]  PADDR;

    int errors = 0;
    int checks = 0;
    logic model_last;

    // observations of one transfer
    logic [1:0]    o_ready, o_resp, o_resp_next;
    logic          o_setup_ok, o_pwrite, o_err, o_psel_after, o_stable;
    logic [AW-1:0] o_paddr;
    logic [DW-1:0] o_pwdata, o_rdata;
    int            o_en, o_lat;

    apb_master_arbiter #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic model_grant(input logic [1:0] v);
        return (v == 2'b11) ? ~model_last : v[1];
    endfunction

    // Drives one command and a slave that answers after `waits` wait states.
    task automatic run_xfer(input logic [1:0] valid, input logic [1:0] wr,
                            input logic [AW2-1:0] addr, input logic [2*DW-1:0] wdata,
                            input int waits, input logic [DW-1:0] rdata, input logic slverr);
        int guard;
        @(negedge PCLK);
        req_valid = valid; req_write = wr; req_addr = addr; req_wdata = wdata;
        PREADY = 1'b0; PRDATA = rdata; PSLVERR = slverr;
        #1;
        guard = 0;
        while (req_ready == 2'b00 && guard < 8) begin
            @(negedge PCLK); #1; guard++;
        end
        o_ready = req_ready;
        @(negedge PCLK);
        req_valid = 2'b00;
        req_write = 2'($urandom); req_addr = AW2'($urandom); req_wdata = {$urandom, $urandom};
        o_setup_ok = PSEL && !PENABLE;
        o_paddr = PADDR; o_pwrite = PWRITE; o_pwdata = PWDATA;
        o_lat = 1; o_en = 0; o_stable = 1'b1;
        guard = 0;
        while (guard < TO + 6) begin
            @(negedge PCLK);
            o_lat++;
            if (!(PSEL && PENABLE)) break;
            o_en++;
            if (PADDR !== o_paddr || PWRITE !== o_pwrite || PWDATA !== o_pwdata) o_stable = 1'b0;
            PREADY = (o_en == waits + 1);
            req_addr = AW2'($urandom);
            guard++;
        end
        o_resp = resp_valid; o_rdata = resp_rdata; o_err = resp_err; o_psel_after = PSEL;
        PREADY = 1'b0;
        @(negedge PCLK);
        o_resp_next = resp_valid;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; req_valid = 2'b11; #2;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {PSEL, PENABLE, PWRITE}); end
        checks++; if (PADDR !== '0 || PWDATA !== '0) begin errors++; $display("FAIL reset_bus got=%h/%h exp=0/0", PADDR, PWDATA); end
        checks++; if (resp_valid !== 2'b00 || resp_rdata !== '0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b/%h/%b exp=00/0/0", resp_valid, resp_rdata, resp_err); end
        @(negedge PCLK); req_valid = 2'b00; PRESETn = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_write();
        run_xfer(2'b01, 2'b01, {4'h9, 4'h4}, {32'h1111_2222, 32'hA5A5_0001}, 0, 32'hFFFF_FFFF, 1'b0);
        checks++; if (o_ready !== 2'b01) begin errors++; $display("FAIL wr_ready got=%b exp=01", o_ready); end
        checks++; if (o_setup_ok !== 1'b1) begin errors++; $display("FAIL wr_setup got=%b exp=1", o_setup_ok); end
        checks++; if (o_paddr !== 4'h4 || o_pwdata !== 32'hA5A5_0001 || o_pwrite !== 1'b1) begin errors++; $display("FAIL wr_bus got=%h/%h/%b exp=4/a5a50001/1", o_paddr, o_pwdata, o_pwrite); end
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL wr_latency got=%0d exp=3", o_lat); end
        checks++; if (o_resp !== 2'b01 || o_err !== 1'b0 || o_rdata !== '0) begin errors++; $display("FAIL wr_resp got=%b/%b/%h exp=01/0/0", o_resp, o_err, o_rdata); end
        checks++; if (o_resp_next !== 2'b00) begin errors++; $display("FAIL wr_resp_pulse got=%b exp=00", o_resp_next); end
        model_last = 1'b0;
    endtask

    task automatic test_read_wait();
        run_xfer(2'b10, 2'b00, {4'h0, 4'hC}, {32'h0, 32'h0}, 3, 32'h1234_5678, 1'b0);
        checks++; if (o_ready !== 2'b10) begin errors++; $display("FAIL rd_ready got=%b exp=10", o_ready); end
        checks++; if (o_en !== 4 || o_stable !== 1'b1) begin errors++; $display("FAIL rd_penable got=%0d stable=%b exp=4 stable=1", o_en, o_stable); end
        checks++; if (o_paddr !== 4'h0 || o_pwrite !== 1'b0) begin errors++; $display("FAIL rd_bus got=%h/%b exp=0/0", o_paddr, o_pwrite); end
        checks++; if (o_resp !== 2'b10 || o_rdata !== 32'h1234_5678 || o_err !== 1'b0) begin errors++; $display("FAIL rd_resp got=%b/%h/%b exp=10/12345678/0", o_resp, o_rdata, o_err); end
        model_last = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_r [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge PCLK); PRESETn = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1; model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_xfer(2'b11, 2'($urandom), AW2'($urandom), {$urandom, $urandom}, 0, $urandom, 1'b0);
            checks++; if (o_ready !== exp_r[i]) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, o_ready, exp_r[i]); end
            model_last = exp_r[i][1];
        end
    endtask

    task automatic test_timeout();
        run_xfer(2'b01, 2'b00, {4'h3, 4'h7}, {32'h0, 32'h0}, 100, 32'hDEAD_BEEF, 1'b0);
        checks++; if (o_en !== TO) begin errors++; $display("FAIL to_access_len got=%0d exp=%0d", o_en, TO); end
        checks++; if (o_resp !== 2'b01 || o_err !== 1'b1 || o_rdata !== '0) begin errors++; $display("FAIL to_resp got=%b/%b/%h exp=01/1/0", o_resp, o_err, o_rdata); end
        checks++; if (o_psel_after !== 1'b0) begin errors++; $display("FAIL to_psel_drop got=%b exp=0", o_psel_after); end
        model_last = 1'b0;
    endtask

    task automatic test_slverr();
        run_xfer(2'b10, 2'b00, {4'h5, 4'h1}, {32'h0, 32'h0}, 1, 32'h0BAD_F00D, 1'b1);
        checks++; if (o_resp !== 2'b10 || o_err !== 1'b1) begin errors++; $display("FAIL slverr_resp got=%b/%b exp=10/1", o_resp, o_err); end
        checks++; if (o_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL slverr_rdata got=%h exp=0badf00d", o_rdata); end
        checks++; if (o_resp_next !== 2'b00) begin errors++; $display("FAIL slverr_pulse got=%b exp=00", o_resp_next); end
        model_last = 1'b1;
    endtask

    task automatic test_reset_mid();
        int guard;
        logic seen;
        @(negedge PCLK);
        req_valid = 2'b10; req_write = 2'b00; PREADY = 1'b0; PSLVERR = 1'b0;
        #1; guard = 0;
        while (req_ready == 2'b00 && guard < 8) begin @(negedge PCLK); #1; guard++; end
        @(negedge PCLK); req_valid = 2'b00;
        @(negedge PCLK);
        checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_in_access got=%b exp=1", PENABLE); end
        #2 PRESETn = 1'b0;
        #1;
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin errors++; $display("FAIL rstmid_async got=%b%b exp=00", PSEL, PENABLE); end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge PCLK); if (resp_valid !== 2'b00) seen = 1'b1; end
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge PCLK); if (resp_valid !== 2'b00 || PSEL !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume got=%b exp=0", seen); end
        model_last = 1'b1;
        run_xfer(2'b11, 2'b11, AW2'($urandom), {$urandom, $urandom}, 0, $urandom, 1'b0);
        checks++; if (o_ready !== 2'b01) begin errors++; $display("FAIL rstmid_tie got=%b exp=01", o_ready); end
        model_last = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]      v, w;
        logic [AW2-1:0]  a;
        logic [2*DW-1:0] d;
        logic [DW-1:0]   rd;
        logic            se, g, to;
        int              waits, exp_en;
        for (int i = 0; i < 30; i++) begin
            v  = 2'($urandom_range(1, 3));
            w  = 2'($urandom);
            a  = AW2'($urandom);
            d  = {$urandom, $urandom};
            rd = $urandom;
            se = ($urandom_range(0, 3) == 0);
            waits = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            g  = model_grant(v);
            to = (waits >= TO);
            exp_en = to ? TO : waits + 1;
            run_xfer(v, w, a, d, waits, rd, se);
            checks++; if (o_ready !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd%0d_grant got=%b exp=%b", i, o_ready, g ? 2'b10 : 2'b01); end
            checks++; if (o_paddr !== a[g*AW +: AW] || o_pwrite !== w[g] || o_pwdata !== d[g*DW +: DW]) begin errors++; $display("FAIL rnd%0d_cmd got=%h/%b/%h exp=%h/%b/%h", i, o_paddr, o_pwrite, o_pwdata, a[g*AW +: AW], w[g], d[g*DW +: DW]); end
            checks++; if (o_en !== exp_en || o_lat !== exp_en + 2 || o_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_timing got=%0d/%0d/%b exp=%0d/%0d/1", i, o_en, o_lat, o_stable, exp_en, exp_en + 2); end
            checks++; if (o_resp !== (g ? 2'b10 : 2'b01) || o_err !== (to | se) || o_rdata !== ((to || w[g]) ? '0 : rd)) begin errors++; $display("FAIL rnd%0d_resp got=%b/%b/%h exp=%b/%b/%h", i, o_resp, o_err, o_rdata, g ? 2'b10 : 2'b01, to | se, (to || w[g]) ? '0 : rd); end
            model_last = g;
        end
    endtask

    initial begin
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge PCLK); @(negedge PCLK);
        test_reset();
        test_write();
        test_read_wait();
        test_round_robin();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
